// File: rtl/ahb_slave_port_mux.sv
// AHB slave-port multiplexer: steers the granted master onto the slave port,
// tracks the data-phase owner for response routing, and aborts hung transfers.
module ahb_slave_port_mux #(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 16
) (
    input  logic                           hclk,
    input  logic                           hreset,
    input  logic [MASTER_NUM-1:0]          hgrant,
    input  logic [MASTER_NUM*ADDR_W-1:0]   m_haddr,
    input  logic [MASTER_NUM*2-1:0]        m_htrans,
    input  logic [MASTER_NUM-1:0]          m_hwrite,
    input  logic [MASTER_NUM*3-1:0]        m_hsize,
    input  logic [MASTER_NUM*3-1:0]        m_hburst,
    input  logic [MASTER_NUM*DATA_W-1:0]   m_hwdata,
    output logic                           s_hsel,
    output logic [ADDR_W-1:0]              s_haddr,
    output logic [1:0]                     s_htrans,
    output logic                           s_hwrite,
    output logic [2:0]                     s_hsize,
    output logic [2:0]                     s_hburst,
    output logic [DATA_W-1:0]              s_hwdata,
    input  logic                           s_hreadyout,
    input  logic                           s_hresp,
    input  logic [DATA_W-1:0]              s_hrdata,
    output logic [MASTER_NUM-1:0]          m_hready,
    output logic [MASTER_NUM-1:0]          m_hresp,
    output logic [DATA_W-1:0]              m_hrdata,
    output logic [2:0]                     arb_hburst,
    output logic                           arb_hwait,
    output logic [MASTER_NUM-1:0]          dphase_owner,
    output logic                           timeout_err
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {NORMAL, ERR1, ERR2} state_t;

    state_t                  state_reg;
    logic [MASTER_NUM-1:0]   downer_reg;
    logic [WCNT_W-1:0]       wcnt_reg;
    logic [2:0]              arb_hburst_reg;

    logic [ADDR_W-1:0]       haddr_arr  [MASTER_NUM];
    logic [1:0]              htrans_arr [MASTER_NUM];
    logic [2:0]              hsize_arr  [MASTER_NUM];
    logic [2:0]              hburst_arr [MASTER_NUM];
    logic [DATA_W-1:0]       hwdata_arr [MASTER_NUM];

    generate
        for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_unpack
            assign haddr_arr[gi]  = m_haddr[gi*ADDR_W +: ADDR_W];
            assign htrans_arr[gi] = m_htrans[gi*2 +: 2];
            assign hsize_arr[gi]  = m_hsize[gi*3 +: 3];
            assign hburst_arr[gi] = m_hburst[gi*3 +: 3];
            assign hwdata_arr[gi] = m_hwdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Outputs see reset immediately so a held reset never leaks a stale owner.
    state_t                state;
    logic [MASTER_NUM-1:0] downer;
    logic [MASTER_NUM-1:0] aowner;
    logic                  grant_onehot;

    assign state        = hreset ? NORMAL : state_reg;
    assign downer       = hreset ? '0 : downer_reg;
    assign grant_onehot = (hgrant != '0) && ((hgrant & (hgrant - MASTER_NUM'(1))) == '0);
    assign aowner       = grant_onehot ? hgrant : '0;

    always_comb begin
        s_haddr  = '0;
        s_htrans = '0;
        s_hwrite = 1'b0;
        s_hsize  = '0;
        s_hburst = '0;
        if (state == NORMAL) begin
            for (int i = 0; i < MASTER_NUM; i++) begin
                if (aowner[i]) begin
                    s_haddr  = haddr_arr[i];
                    s_htrans = htrans_arr[i];
                    s_hwrite = m_hwrite[i];
                    s_hsize  = hsize_arr[i];
                    s_hburst = hburst_arr[i];
                end
            end
        end
    end

    assign s_hsel = s_htrans[1];

    always_comb begin
        s_hwdata = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (downer[i]) begin
                s_hwdata = hwdata_arr[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_resp
            always_comb begin
                case (state)
                    ERR1: begin
                        m_hready[gi] = 1'b0;
                        m_hresp[gi]  = downer[gi];
                    end
                    ERR2: begin
                        m_hready[gi] = downer[gi];
                        m_hresp[gi]  = downer[gi];
                    end
                    default: begin
                        m_hready[gi] = (downer[gi] | aowner[gi]) & s_hreadyout;
                        m_hresp[gi]  = downer[gi] & s_hresp;
                    end
                endcase
            end
        end
    endgenerate

    assign m_hrdata     = s_hrdata;
    assign dphase_owner = downer;
    assign timeout_err  = (state == ERR2);
    assign arb_hburst   = arb_hburst_reg;
    assign arb_hwait    = (state == ERR1) ? 1'b1 :
                          (state == ERR2) ? 1'b0 : ~s_hreadyout;

    logic wd_fire;
    logic accept_nonseq;

    assign wd_fire = (state_reg == NORMAL) && !s_hreadyout && (downer_reg != '0) &&
                     (wcnt_reg == WCNT_W'(MAX_WAIT - 1));
    assign accept_nonseq = s_hsel && s_hreadyout && (s_htrans == HTRANS_NONSEQ);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg      <= NORMAL;
            downer_reg     <= '0;
            wcnt_reg       <= '0;
            arb_hburst_reg <= 3'd0;
        end else begin
            if (s_hreadyout || downer_reg == '0) begin
                wcnt_reg <= '0;
            end else if (wcnt_reg != WCNT_W'(MAX_WAIT)) begin
                wcnt_reg <= wcnt_reg + WCNT_W'(1);
            end

            case (state_reg)
                NORMAL: begin
                    if (wd_fire) begin
                        state_reg <= ERR1;
                    end else if (s_hreadyout) begin
                        downer_reg <= s_hsel ? aowner : '0;
                    end
                end
                ERR1: state_reg <= ERR2;
                ERR2: begin
                    state_reg  <= NORMAL;
                    downer_reg <= '0;
                end
                default: state_reg <= NORMAL;
            endcase

            // Only a NONSEQ starts a new burst; SEQ beats keep the recorded type.
            if (accept_nonseq) begin
                arb_hburst_reg <= s_hburst;
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// Directed bench for ahb_slave_port_mux with a write-data scoreboard and a
// short watchdog (MAX_WAIT=4).
module tb_ahb_slave_port_mux;

    localparam int MN = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;
    localparam logic [2:0] SINGLE = 3'd0, WRAP4 = 3'd2, INCR4 = 3'd3, INCR8 = 3'd5;
    localparam logic [31:0] WD0 = 32'hA0A0_0001, WD1 = 32'hB1B1_0002;

    logic            clk = 1'b0;
    logic            hreset;
    logic [MN-1:0]   hgrant;
    logic [MN*AW-1:0] m_haddr;
    logic [MN*2-1:0] m_htrans;
    logic [MN-1:0]   m_hwrite;
    logic [MN*3-1:0] m_hsize;
    logic [MN*3-1:0] m_hburst;
    logic [MN*DW-1:0] m_hwdata;
    logic            s_hsel;
    logic [AW-1:0]   s_haddr;
    logic [1:0]      s_htrans;
    logic            s_hwrite;
    logic [2:0]      s_hsize;
    logic [2:0]      s_hburst;
    logic [DW-1:0]   s_hwdata;
    logic            s_hreadyout;
    logic            s_hresp;
    logic [DW-1:0]   s_hrdata;
    logic [MN-1:0]   m_hready;
    logic [MN-1:0]   m_hresp;
    logic [DW-1:0]   m_hrdata;
    logic [2:0]      arb_hburst;
    logic            arb_hwait;
    logic [MN-1:0]   dphase_owner;
    logic            timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [MN-1:0] owner;
        logic [DW-1:0] wdata;
    } sb_t;
    sb_t exp_q[$];

    ahb_slave_port_mux #(
        .MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)
    ) dut (
        .hclk(clk), .hreset(hreset), .hgrant(hgrant),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans),
        .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
        .s_hwdata(s_hwdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
        .s_hrdata(s_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
        .m_hrdata(m_hrdata), .arb_hburst(arb_hburst), .arb_hwait(arb_hwait),
        .dphase_owner(dphase_owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [MN-1:0] owner, input logic [DW-1:0] wdata);
        sb_t e;
        e.owner = owner;
        e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        sb_t e;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_owner"}, 64'(dphase_owner), 64'(e.owner));
            chk({tag, "_wdata"}, 64'(s_hwdata), 64'(e.wdata));
        end
    endtask

    task automatic drive_m(input int i, input logic [AW-1:0] addr,
                           input logic [1:0] trans, input logic [2:0] burst);
        m_haddr[i*AW +: AW] = addr;
        m_htrans[i*2 +: 2]  = trans;
        m_hburst[i*3 +: 3]  = burst;
        m_hwrite[i]         = 1'b1;
        m_hsize[i*3 +: 3]   = 3'd2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        hreset = 1'b1; hgrant = '0; m_haddr = '0; m_htrans = '0; m_hwrite = '0;
        m_hsize = '0; m_hburst = '0; m_hwdata = {WD1, WD0};
        s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_owner", 64'(dphase_owner), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_hburst", 64'(arb_hburst), 64'(SINGLE));
        chk("rst_hwdata", 64'(s_hwdata), 64'd0);
        chk("rst_hresp", 64'(m_hresp), 64'd0);
        chk("rst_hsel", 64'(s_hsel), 64'd0);

        // M0 NONSEQ write INCR4 at 0x100
        tick();
        hreset = 1'b0; hgrant = 2'b01; drive_m(0, 32'h100, NONSEQ, INCR4);
        @(negedge clk);
        chk("a0_hsel", 64'(s_hsel), 64'd1);
        chk("a0_haddr", 64'(s_haddr), 64'h100);
        chk("a0_htrans", 64'(s_htrans), 64'(NONSEQ));
        chk("a0_hwrite", 64'(s_hwrite), 64'd1);
        chk("a0_hsize", 64'(s_hsize), 64'd2);
        chk("a0_hburst", 64'(s_hburst), 64'(INCR4));
        chk("a0_hready", 64'(m_hready), 64'b01);
        chk("a0_owner", 64'(dphase_owner), 64'd0);
        sb_push(2'b01, WD0);

        // M0 data phase, M1 address, slave waits two cycles
        tick();
        hgrant = 2'b10; drive_m(0, 32'h0, IDLE, SINGLE); drive_m(1, 32'h200, NONSEQ, WRAP4);
        s_hreadyout = 1'b0;
        @(negedge clk);
        sb_check("d0");
        chk("d0_arbburst", 64'(arb_hburst), 64'(INCR4));
        chk("w1_hready", 64'(m_hready), 64'b00);
        chk("w1_haddr", 64'(s_haddr), 64'h200);
        chk("w1_hwait", 64'(arb_hwait), 64'd1);
        tick();
        @(negedge clk);
        chk("w2_owner", 64'(dphase_owner), 64'b01);
        chk("w2_hready", 64'(m_hready), 64'b00);
        tick();
        s_hreadyout = 1'b1;
        @(negedge clk);
        chk("w3_hready", 64'(m_hready), 64'b11);
        chk("w3_hwait", 64'(arb_hwait), 64'd0);
        sb_push(2'b10, WD1);

        // M1 data phase with slave ERROR; zero grant issues no address
        tick();
        hgrant = 2'b00; drive_m(0, 32'h300, NONSEQ, INCR8); drive_m(1, 32'h340, NONSEQ, INCR8);
        s_hresp = 1'b1; s_hrdata = 32'h1234_5678;
        @(negedge clk);
        sb_check("d1");
        chk("d1_arbburst", 64'(arb_hburst), 64'(WRAP4));
        chk("d1_hresp", 64'(m_hresp), 64'b10);
        chk("d1_hready", 64'(m_hready), 64'b10);
        chk("g00_hsel", 64'(s_hsel), 64'd0);
        chk("g00_htrans", 64'(s_htrans), 64'(IDLE));
        chk("g00_haddr", 64'(s_haddr), 64'd0);
        chk("g00_hburst", 64'(s_hburst), 64'd0);
        chk("d1_hrdata", 64'(m_hrdata), 64'h1234_5678);

        // Multi-hot grant
        tick();
        hgrant = 2'b11; s_hresp = 1'b0;
        @(negedge clk);
        chk("g00_owner", 64'(dphase_owner), 64'd0);
        chk("g11_hsel", 64'(s_hsel), 64'd0);
        chk("g11_htrans", 64'(s_htrans), 64'(IDLE));
        chk("g11_hready", 64'(m_hready), 64'b00);
        chk("g11_hwdata", 64'(s_hwdata), 64'd0);
        chk("g11_hresp", 64'(m_hresp), 64'b00);

        // New M0 transfer INCR8, then slave hangs
        tick();
        hgrant = 2'b01; s_hrdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("g11_owner", 64'(dphase_owner), 64'd0);
        chk("hold_arbburst", 64'(arb_hburst), 64'(WRAP4));
        chk("a2_hsel", 64'(s_hsel), 64'd1);
        chk("a2_hrdata", 64'(m_hrdata), 64'hCAFE_F00D);
        sb_push(2'b01, WD0);

        tick();
        hgrant = 2'b00; s_hreadyout = 1'b0;
        @(negedge clk);
        sb_check("d2");
        chk("d2_arbburst", 64'(arb_hburst), 64'(INCR8));
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("wd%0d_hready", w), 64'(m_hready), 64'b00);
            chk($sformatf("wd%0d_hresp", w), 64'(m_hresp), 64'b00);
            chk($sformatf("wd%0d_timeout", w), 64'(timeout_err), 64'd0);
            chk($sformatf("wd%0d_owner", w), 64'(dphase_owner), 64'b01);
            tick();
            if (w == 3) hgrant = 2'b01;
            @(negedge clk);
        end
        chk("err1_hready", 64'(m_hready), 64'b00);
        chk("err1_hresp", 64'(m_hresp), 64'b01);
        chk("err1_hwait", 64'(arb_hwait), 64'd1);
        chk("err1_hsel", 64'(s_hsel), 64'd0);
        chk("err1_timeout", 64'(timeout_err), 64'd0);
        chk("err1_owner", 64'(dphase_owner), 64'b01);
        tick();
        @(negedge clk);
        chk("err2_hready", 64'(m_hready), 64'b01);
        chk("err2_hresp", 64'(m_hresp), 64'b01);
        chk("err2_timeout", 64'(timeout_err), 64'd1);
        chk("err2_hwait", 64'(arb_hwait), 64'd0);
        chk("err2_hsel", 64'(s_hsel), 64'd0);
        tick();
        hgrant = 2'b00; s_hreadyout = 1'b1;
        @(negedge clk);
        chk("post_owner", 64'(dphase_owner), 64'd0);
        chk("post_timeout", 64'(timeout_err), 64'd0);
        chk("post_hresp", 64'(m_hresp), 64'b00);

        // Second hang, reset asserted during ERR1
        tick();
        hgrant = 2'b01; drive_m(0, 32'h400, NONSEQ, INCR4);
        @(negedge clk);
        chk("a3_hsel", 64'(s_hsel), 64'd1);
        sb_push(2'b01, WD0);
        tick();
        hgrant = 2'b00; s_hreadyout = 1'b0;
        @(negedge clk);
        sb_check("d3");
        chk("d3_arbburst", 64'(arb_hburst), 64'(INCR4));
        repeat (4) tick();
        @(negedge clk);
        chk("rerr1_hresp", 64'(m_hresp), 64'b01);
        chk("rerr1_hready", 64'(m_hready), 64'b00);
        hreset = 1'b1;
        tick();
        hreset = 1'b0; s_hreadyout = 1'b1;
        @(negedge clk);
        chk("rr_owner", 64'(dphase_owner), 64'd0);
        chk("rr_timeout", 64'(timeout_err), 64'd0);
        chk("rr_arbburst", 64'(arb_hburst), 64'(SINGLE));
        chk("rr_hresp", 64'(m_hresp), 64'b00);
        chk("rr_hwait", 64'(arb_hwait), 64'd0);
        chk("rr_hready", 64'(m_hready), 64'b00);
        tick();
        @(negedge clk);
        chk("rr2_timeout", 64'(timeout_err), 64'd0);
        chk("rr2_owner", 64'(dphase_owner), 64'd0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
